// File: rtl/rng_fetch_pkg.sv
// Shared constants for the RNG block fetcher: FSM state codes, generator
// interface widths and the block-to-word count helper.
package rng_fetch_pkg;

    localparam int RNG_MAXBITS_W = 12;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_REQ   = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_CHECK = 3'd3;
    localparam state_t ST_DRAIN = 3'd4;
    localparam state_t ST_FAIL  = 3'd5;

    function automatic int word_count(input int nbits, input int wbits);
        return nbits / wbits;
    endfunction

endpackage

// File: rtl/rng_block_check.sv
// Block sanity checker: flags all-zeros, all-ones, or a repeat of the last
// accepted block. The verdict is registered so the wide compares get a full cycle.
module rng_block_check
    import rng_fetch_pkg::*;
#(
    parameter int NBITS = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NBITS-1:0] blk,
    input  logic [NBITS-1:0] prev,
    input  logic             prev_valid,
    output logic             reject
);

    logic reject_reg;
    logic reject_next;

    always_comb begin
        reject_next = (blk == '0) || (blk == '1) || (prev_valid && (blk == prev));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reject_reg <= 1'b0;
        end else begin
            reject_reg <= reject_next;
        end
    end

    assign reject = reject_reg;

endmodule

// File: rtl/rng_block_fetch.sv
// Requester side of the RNG enable_p/done_p handshake: fetches NBITS blocks,
// sanity-checks them with retry/timeout, and streams them out LSB word first.
module rng_block_fetch
    import rng_fetch_pkg::*;
#(
    parameter int NBITS    = 256,
    parameter int WBITS    = 32,
    parameter int TIMEOUT  = 4096,
    parameter int MAXRETRY = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_en,
    input  logic                     clr_fail,
    output logic                     rng_enable_p,
    output logic [RNG_MAXBITS_W-1:0] rng_maxbits,
    input  logic                     rng_done_p,
    input  logic [NBITS-1:0]         rng_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WBITS-1:0]         out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     fail
);

    localparam int NWORDS = word_count(NBITS, WBITS);
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NWORDS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [2:0]       RETRY_MAX = 3'(MAXRETRY);

    state_t           state_reg, state_next;
    logic [TMR_W-1:0] timer_reg, timer_next;
    logic [2:0]       retry_reg, retry_next;
    logic [2:0]       retry_inc;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [NBITS-1:0] blk_reg, blk_next;
    logic [NBITS-1:0] prev_reg, prev_next;
    logic             prev_valid_reg, prev_valid_next;
    logic             fail_attempt;
    logic             reject;
    logic [WBITS-1:0] words [NWORDS];

    // The checker sees the word as it is captured, so its registered verdict
    // is ready exactly in the CHECK cycle; prev cannot change during WAIT.
    rng_block_check #(
        .NBITS(NBITS)
    ) u_check (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk       (rng_y),
        .prev      (prev_reg),
        .prev_valid(prev_valid_reg),
        .reject    (reject)
    );

    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_words
        assign words[gi] = blk_reg[gi*WBITS +: WBITS];
    end

    always_comb begin
        state_next      = state_reg;
        timer_next      = timer_reg;
        retry_next      = retry_reg;
        idx_next        = idx_reg;
        blk_next        = blk_reg;
        prev_next       = prev_reg;
        prev_valid_next = prev_valid_reg;
        retry_inc       = retry_reg + 3'd1;
        fail_attempt    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (req_en) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                timer_next = '0;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                timer_next = timer_reg + 1'b1;
                // A done pulse on the final timer cycle still counts.
                if (rng_done_p) begin
                    blk_next   = rng_y;
                    state_next = ST_CHECK;
                end else if (timer_reg == TMR_LAST) begin
                    fail_attempt = 1'b1;
                end
            end
            ST_CHECK: begin
                if (reject) begin
                    fail_attempt = 1'b1;
                end else begin
                    prev_next       = blk_reg;
                    prev_valid_next = 1'b1;
                    retry_next      = '0;
                    idx_next        = '0;
                    state_next      = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = req_en ? ST_REQ : ST_IDLE;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            ST_FAIL: begin
                if (clr_fail) begin
                    state_next      = ST_IDLE;
                    retry_next      = '0;
                    prev_valid_next = 1'b0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (fail_attempt) begin
            retry_next = retry_inc;
            state_next = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            timer_reg      <= '0;
            retry_reg      <= '0;
            idx_reg        <= '0;
            blk_reg        <= '0;
            prev_reg       <= '0;
            prev_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            retry_reg      <= retry_next;
            idx_reg        <= idx_next;
            blk_reg        <= blk_next;
            prev_reg       <= prev_next;
            prev_valid_reg <= prev_valid_next;
        end
    end

    assign rng_enable_p = (state_reg == ST_REQ);
    assign rng_maxbits  = RNG_MAXBITS_W'(NBITS);
    assign out_valid    = (state_reg == ST_DRAIN);
    assign out_data     = words[idx_reg];
    assign out_last     = out_valid && (idx_reg == LAST_IDX);
    assign busy         = (state_reg != ST_IDLE) && (state_reg != ST_FAIL);
    assign fail         = (state_reg == ST_FAIL);

endmodule

// File: tb/tb_rng_block_fetch.sv
// Directed bench for rng_block_fetch: a scripted generator, a block-level
// acceptance model feeding an expected-word scoreboard, and literal pin checks.
module tb_rng_block_fetch;

    localparam int NBITS    = 256;
    localparam int WBITS    = 32;
    localparam int TIMEOUT  = 16;
    localparam int MAXRETRY = 3;
    localparam int NW       = NBITS / WBITS;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_en;
    logic             clr_fail;
    logic             rng_done_p;
    logic [NBITS-1:0] rng_y;
    logic             out_ready;
    logic             rng_enable_p;
    logic [11:0]      rng_maxbits;
    logic             out_valid;
    logic [WBITS-1:0] out_data;
    logic             out_last;
    logic             busy;
    logic             fail;

    rng_block_fetch #(
        .NBITS(NBITS), .WBITS(WBITS), .TIMEOUT(TIMEOUT), .MAXRETRY(MAXRETRY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_en(req_en), .clr_fail(clr_fail),
        .rng_enable_p(rng_enable_p), .rng_maxbits(rng_maxbits),
        .rng_done_p(rng_done_p), .rng_y(rng_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .fail(fail)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // generator script: one entry consumed per request pulse
    int               sc_delay[$];
    logic [NBITS-1:0] sc_data[$];
    bit               sc_resp[$];

    // model of which blocks must come out
    logic [NBITS-1:0] m_prev;
    bit               m_prev_v;
    int               m_fails;
    bit               m_fail;
    logic [WBITS-1:0] exp_w[$];
    bit               exp_l[$];

    // observation logs
    int               en_cyc[$];
    int               hs_cyc[$];
    int               fv_cyc[$];
    logic [WBITS-1:0] hs_data[$];
    bit               hs_last[$];

    bit               bp_mode;
    int               stray_cnt;
    logic [NBITS-1:0] stray_data;

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_word(input string name, input logic [WBITS-1:0] act,
                            input logic [WBITS-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_prev_v = 1'b0;
        m_fails  = 0;
        m_fail   = 1'b0;
    endtask

    task automatic model_fail_attempt();
        m_fails++;
        if (m_fails == MAXRETRY) m_fail = 1'b1;
    endtask

    task automatic model_deliver(input logic [NBITS-1:0] d);
        if (d == '0 || d == '1 || (m_prev_v && d == m_prev)) begin
            model_fail_attempt();
        end else begin
            for (int i = 0; i < NW; i++) begin
                exp_w.push_back(d[i*WBITS +: WBITS]);
                exp_l.push_back(i == NW - 1);
            end
            m_prev   = d;
            m_prev_v = 1'b1;
            m_fails  = 0;
        end
    endtask

    task automatic push_script(input int dly, input logic [NBITS-1:0] d, input bit resp);
        sc_delay.push_back(dly);
        sc_data.push_back(d);
        sc_resp.push_back(resp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Generator: answers each request after its scripted delay (counted in
    // cycles from the enable cycle); answers for an abandoned request are stale.
    initial begin : responder
        int               cnt;
        int               dly;
        int               stray_sent;
        bit               pend;
        bit               stale;
        bit               resp;
        logic [NBITS-1:0] d;
        cnt = 0; pend = 1'b0; stale = 1'b0; stray_sent = 0; d = '0;
        rng_done_p = 1'b0;
        rng_y = '0;
        model_clear();
        forever begin
            @(negedge clk);
            rng_done_p = 1'b0;
            if (!rst_n) begin
                stale = 1'b1;
                model_clear();
            end
            if (clr_fail && m_fail) model_clear();
            if (stray_sent != stray_cnt) begin
                stray_sent = stray_cnt;
                rng_y = stray_data;
                rng_done_p = 1'b1;
            end else if (pend) begin
                cnt--;
                if (cnt <= 0) begin
                    pend = 1'b0;
                    rng_y = d;
                    rng_done_p = 1'b1;
                    if (!stale) model_deliver(d);
                end
            end
            if (rng_enable_p) begin
                en_cyc.push_back(cyc);
                $display("cyc %0d: request pulse", cyc);
                if (sc_delay.size() > 0) begin
                    dly  = sc_delay.pop_front();
                    d    = sc_data.pop_front();
                    resp = sc_resp.pop_front();
                    if (resp) begin
                        pend = 1'b1; cnt = dly; stale = 1'b0;
                    end else begin
                        model_fail_attempt();
                    end
                end else begin
                    model_fail_attempt();
                end
            end
        end
    end

    initial begin : ready_drv
        int k;
        k = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                out_ready = (k % 4 == 0) || (k % 4 == 3);
                k++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Scoreboard: every handshake must match the next expected word; a stalled
    // word must stay put until taken.
    initial begin : compare
        bit               held;
        bit               in_blk;
        bit               el;
        logic [WBITS-1:0] held_data;
        logic [WBITS-1:0] ew;
        held = 1'b0; in_blk = 1'b0; held_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
                in_blk = 1'b0;
            end else if (out_valid) begin
                if (!in_blk) begin
                    in_blk = 1'b1;
                    fv_cyc.push_back(cyc);
                end
                if (held) chk_word("stall_stable", out_data, held_data);
                if (out_ready) begin
                    held = 1'b0;
                    chk_int("valid_expected", int'(exp_w.size() > 0), 1);
                    if (exp_w.size() > 0) begin
                        ew = exp_w.pop_front();
                        el = exp_l.pop_front();
                        chk_word("word_data", out_data, ew);
                        chk_int("word_last", int'(out_last), int'(el));
                        if (el) in_blk = 1'b0;
                    end
                    hs_cyc.push_back(cyc);
                    hs_data.push_back(out_data);
                    hs_last.push_back(out_last);
                    $display("cyc %0d: word %h last %0b", cyc, out_data, out_last);
                end else begin
                    held = 1'b1;
                    held_data = out_data;
                end
            end else begin
                if (held) chk_int("stall_keeps_valid", int'(out_valid), 1);
                held = 1'b0;
            end
        end
    end

    task automatic wait_en(input int n, input int budget);
        int k;
        k = 0;
        while (en_cyc.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk_int("wait_request", int'(en_cyc.size() >= n), 1);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((busy || exp_w.size() != 0) && k < budget);
        chk_int("reach_idle", int'(!busy && exp_w.size() == 0), 1);
    endtask

    initial begin : main
        int               e0, h0, f0, k;
        logic [NBITS-1:0] blk_a, blk_b, blk_c, blk_d, blk_e, blk_g;

        rst_n = 1'b0; req_en = 1'b0; clr_fail = 1'b0;
        bp_mode = 1'b0; stray_cnt = 0; stray_data = '0;
        blk_a = 256'h89ABCDEF_76543210_FEDCBA98_01234567_DEADBEEF_CAFEF00D_13579BDF_02468ACE;
        blk_b = ~blk_a;
        blk_c = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
        blk_d = 256'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3_E4E4E4E4_F5F5F5F5_06060606_17171717;
        blk_e = 256'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0_00000001_80000000_FFFFFFFE_7FFFFFFF;
        blk_g = ~blk_e;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_int("rst_enable", int'(rng_enable_p), 0);
        chk_int("rst_valid", int'(out_valid), 0);
        chk_int("rst_last", int'(out_last), 0);
        chk_int("rst_busy", int'(busy), 0);
        chk_int("rst_fail", int'(fail), 0);
        chk_word("rst_data", out_data, 32'h0);
        chk_int("rst_maxbits", int'(rng_maxbits), 256);
        step();
        rst_n = 1'b1;
        step();

        // nominal: two back-to-back blocks, no stalls
        e0 = en_cyc.size(); h0 = hs_cyc.size(); f0 = fv_cyc.size();
        push_script(10, blk_a, 1'b1);
        push_script(10, blk_b, 1'b1);
        req_en = 1'b1;
        wait_en(e0 + 2, 200);
        req_en = 1'b0;
        wait_idle(200);
        chk_int("t1_requests", en_cyc.size() - e0, 2);
        chk_int("t1_handshakes", hs_cyc.size() - h0, 2 * NW);
        if (hs_cyc.size() >= h0 + NW && en_cyc.size() >= e0 + 2 && fv_cyc.size() > f0) begin
            chk_int("t1_first_word_latency", fv_cyc[f0] - en_cyc[e0], 12);
            chk_int("t1_no_gaps", hs_cyc[h0+7] - hs_cyc[h0], 7);
            chk_int("t1_next_request", en_cyc[e0+1] - hs_cyc[h0+7], 1);
            chk_word("t1_word0", hs_data[h0], 32'h02468ACE);
            chk_word("t1_word7", hs_data[h0+7], 32'h89ABCDEF);
            chk_int("t1_last_on_8th", int'(hs_last[h0+7]), 1);
            chk_int("t1_not_last_7th", int'(hs_last[h0+6]), 0);
        end

        // backpressure 1,0,0,1,...
        e0 = en_cyc.size(); h0 = hs_cyc.size(); f0 = fv_cyc.size();
        bp_mode = 1'b1;
        push_script(5, blk_c, 1'b1);
        step();
        req_en = 1'b1;
        wait_en(e0 + 1, 100);
        req_en = 1'b0;
        wait_idle(300);
        bp_mode = 1'b0;
        chk_int("t2_handshakes", hs_cyc.size() - h0, NW);
        if (hs_cyc.size() >= h0 + NW && fv_cyc.size() > f0) begin
            chk_int("t2_stalls_seen", int'(hs_cyc[h0+7] - fv_cyc[f0] >= 8), 1);
            chk_word("t2_word3", hs_data[h0+3], 32'h55555555);
        end

        // check reject: all-zeros, then a repeat of the previous block, then good
        e0 = en_cyc.size(); h0 = hs_cyc.size(); f0 = fv_cyc.size();
        push_script(4, '0, 1'b1);
        push_script(4, blk_c, 1'b1);
        push_script(4, blk_d, 1'b1);
        step();
        req_en = 1'b1;
        wait_en(e0 + 3, 200);
        req_en = 1'b0;
        wait_idle(200);
        chk_int("t3_requests", en_cyc.size() - e0, 3);
        chk_int("t3_handshakes", hs_cyc.size() - h0, NW);
        if (en_cyc.size() >= e0 + 3 && hs_cyc.size() >= h0 + NW && fv_cyc.size() > f0) begin
            chk_int("t3_retry_gap0", en_cyc[e0+1] - en_cyc[e0], 6);
            chk_int("t3_retry_gap1", en_cyc[e0+2] - en_cyc[e0+1], 6);
            chk_int("t3_first_word_latency", fv_cyc[f0] - en_cyc[e0+2], 6);
            chk_word("t3_word0", hs_data[h0], 32'h17171717);
        end

        // done on the last timer cycle, plus a stray done during DRAIN
        e0 = en_cyc.size(); h0 = hs_cyc.size(); f0 = fv_cyc.size();
        push_script(TIMEOUT, blk_e, 1'b1);
        step();
        req_en = 1'b1;
        wait_en(e0 + 1, 100);
        req_en = 1'b0;
        k = 0;
        while (!out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk_int("t4_drain_started", int'(out_valid), 1);
        stray_data = {8{32'hBAD0BAD0}};
        stray_cnt++;
        wait_idle(200);
        chk_int("t4_handshakes", hs_cyc.size() - h0, NW);
        chk_int("t4_no_fail", int'(fail), 0);
        if (en_cyc.size() > e0 && hs_cyc.size() >= h0 + NW && fv_cyc.size() > f0) begin
            chk_int("t4_first_word_latency", fv_cyc[f0] - en_cyc[e0], TIMEOUT + 2);
            chk_word("t4_word7", hs_data[h0+7], 32'h0F1E2D3C);
        end

        // reset in the middle of WAIT, late done ignored, prev forgotten
        e0 = en_cyc.size();
        push_script(10, blk_g, 1'b1);
        step();
        req_en = 1'b1;
        wait_en(e0 + 1, 100);
        req_en = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk_int("t5_rst_busy", int'(busy), 0);
        chk_int("t5_rst_valid", int'(out_valid), 0);
        chk_int("t5_rst_enable", int'(rng_enable_p), 0);
        chk_int("t5_rst_fail", int'(fail), 0);
        chk_word("t5_rst_data", out_data, 32'h0);
        repeat (12) step();
        chk_int("t5_late_done_ignored", int'(busy), 0);
        e0 = en_cyc.size(); h0 = hs_cyc.size();
        push_script(5, blk_e, 1'b1);
        req_en = 1'b1;
        wait_en(e0 + 1, 100);
        req_en = 1'b0;
        wait_idle(200);
        chk_int("t5_repeat_accepted", hs_cyc.size() - h0, NW);
        if (hs_cyc.size() >= h0 + NW) chk_word("t5_word0", hs_data[h0], 32'h7FFFFFFF);

        // timeout/retry into FAIL, then clr_fail
        e0 = en_cyc.size();
        push_script(0, '0, 1'b0);
        push_script(0, '0, 1'b0);
        push_script(0, '0, 1'b0);
        step();
        req_en = 1'b1;
        k = 0;
        while (!fail && k < 200) begin
            @(negedge clk);
            k++;
        end
        req_en = 1'b0;
        chk_int("t6_fail", int'(fail), 1);
        chk_int("t6_fail_model", int'(fail), int'(m_fail));
        chk_int("t6_busy", int'(busy), 0);
        chk_int("t6_requests", en_cyc.size() - e0, 3);
        if (en_cyc.size() >= e0 + 3) begin
            chk_int("t6_gap0", en_cyc[e0+1] - en_cyc[e0], TIMEOUT + 1);
            chk_int("t6_gap1", en_cyc[e0+2] - en_cyc[e0+1], TIMEOUT + 1);
        end
        repeat (10) step();
        chk_int("t6_no_more_requests", en_cyc.size() - e0, 3);
        chk_int("t6_still_fail", int'(fail), 1);
        clr_fail = 1'b1;
        step();
        clr_fail = 1'b0;
        @(negedge clk);
        chk_int("t6_clr_fail", int'(fail), 0);
        chk_int("t6_clr_busy", int'(busy), 0);

        // after clr_fail the last accepted block is no longer remembered
        e0 = en_cyc.size(); h0 = hs_cyc.size();
        push_script(3, blk_e, 1'b1);
        step();
        req_en = 1'b1;
        wait_en(e0 + 1, 100);
        req_en = 1'b0;
        wait_idle(200);
        chk_int("t7_accepted_after_clr", hs_cyc.size() - h0, NW);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
